// File: rtl/lb_span_writer.sv
// Draw-side span writer: turns solid-colour horizontal spans into aligned 8-pixel line buffer group writes.
// Optional macro LB_SPAN_CLIP_EN clips spans to [0, LINE_PIXELS) instead of wrapping mod 4096.
module lb_span_writer #(
    parameter int unsigned LINE_PIXELS = 4096
) (
    input  logic        clk_draw,
    input  logic        rst_draw_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [11:0] cmd_x,
    input  logic [12:0] cmd_len,
    input  logic [8:0]  cmd_colour,
    output logic        busy,
    output logic [8:0]  addr_draw,
    output logic [7:0]  we_draw,
    output logic [71:0] colour_draw
);

    localparam int unsigned XW    = 12;
    localparam int unsigned LW    = 13;
    localparam int unsigned CW    = 9;
    localparam int unsigned AW    = 9;
    localparam int unsigned LANES = 8;
    localparam int unsigned DW    = CW * LANES;

    if ((LINE_PIXELS % 8) != 0 || LINE_PIXELS < 8 || LINE_PIXELS > 4096) begin : g_bad_line_pixels
        $error("lb_span_writer: LINE_PIXELS must be a multiple of 8 in 8..4096");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [XW-1:0]       cur_q, cur_d;
    logic [LW-1:0]       rem_q, rem_d;
    logic [CW-1:0]       colour_q, colour_d;
    logic                busy_q, busy_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [LANES-1:0]    we_q, we_d;
    logic [DW-1:0]       cdata_q, cdata_d;

    logic                accept_c;
    logic [LW-1:0]       len_eff_c;
    logic                issue_c;
    logic [XW-1:0]       grp_x_c;
    logic [LW-1:0]       grp_rem_c;
    logic [CW-1:0]       grp_col_c;
    logic [3:0]          avail_c;
    logic [3:0]          n_c;

    // Lane enables for pixel offsets [off, off+n); offset k drives bit 7-k.
    function automatic logic [LANES-1:0] grp_mask(input logic [2:0] off, input logic [3:0] n);
        logic [LANES-1:0] m;
        logic [3:0]       lo;
        logic [3:0]       hi;
        m  = '0;
        lo = {1'b0, off};
        hi = lo + n;
        for (int k = 0; k < 8; k++) begin
            m[3'(7 - k)] = (4'(k) >= lo) && (4'(k) < hi);
        end
        return m;
    endfunction

    assign cmd_ready   = (state_q == ST_IDLE);
    assign accept_c    = cmd_valid && cmd_ready;
    assign busy        = busy_q;
    assign addr_draw   = addr_q;
    assign we_draw     = we_q;
    assign colour_draw = cdata_q;

`ifdef LB_SPAN_CLIP_EN
    localparam logic [LW-1:0] LINE_END = LW'(LINE_PIXELS);

    // Effective pixel count after clipping to the visible line.
    always_comb begin
        logic [LW-1:0] end_c;
        end_c     = {1'b0, cmd_x} + cmd_len;
        len_eff_c = '0;
        if ({1'b0, cmd_x} < LINE_END) begin
            if (end_c > LINE_END) begin
                end_c = LINE_END;
            end
            len_eff_c = end_c - {1'b0, cmd_x};
        end
    end
`else
    // Without clipping, the remaining-pixel count drives wrap-around naturally via 12-bit cur.
    always_comb begin
        len_eff_c = cmd_len;
    end
`endif

    // State register.
    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
        if (!rst_draw_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: RUN while a write is on the outputs; leave once nothing remains.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c && (len_eff_c != '0)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rem_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Group source: the accepted command directly, or the saved cursor while running.
    always_comb begin
        if (state_q == ST_IDLE) begin
            issue_c   = accept_c && (len_eff_c != '0);
            grp_x_c   = cmd_x;
            grp_rem_c = len_eff_c;
            grp_col_c = cmd_colour;
        end else begin
            issue_c   = (rem_q != '0);
            grp_x_c   = cur_q;
            grp_rem_c = rem_q;
            grp_col_c = colour_q;
        end
        avail_c = 4'd8 - {1'b0, grp_x_c[2:0]};
        n_c     = (grp_rem_c >= LW'(avail_c)) ? avail_c : grp_rem_c[3:0];
    end

    // Output/datapath next values.
    always_comb begin
        cur_d    = cur_q;
        rem_d    = rem_q;
        colour_d = colour_q;
        busy_d   = 1'b0;
        addr_d   = addr_q;
        we_d     = '0;
        cdata_d  = cdata_q;
        if (issue_c) begin
            addr_d   = grp_x_c[11:3];
            we_d     = grp_mask(grp_x_c[2:0], n_c);
            cdata_d  = {LANES{grp_col_c}};
            cur_d    = {grp_x_c[11:3] + 9'd1, 3'b000};
            rem_d    = grp_rem_c - LW'(n_c);
            colour_d = grp_col_c;
            busy_d   = 1'b1;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
        if (!rst_draw_n) begin
            cur_q    <= '0;
            rem_q    <= '0;
            colour_q <= '0;
            busy_q   <= 1'b0;
            addr_q   <= '0;
            we_q     <= '0;
            cdata_q  <= '0;
        end else begin
            cur_q    <= cur_d;
            rem_q    <= rem_d;
            colour_q <= colour_d;
            busy_q   <= busy_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            cdata_q  <= cdata_d;
        end
    end

endmodule

// File: tb/tb_lb_span_writer.sv
// Self-checking bench for lb_span_writer (default wrap build): scoreboard of expected group writes.
module tb_lb_span_writer;

    logic        clk_draw;
    logic        rst_draw_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] cmd_x;
    logic [12:0] cmd_len;
    logic [8:0]  cmd_colour;
    logic        busy;
    logic [8:0]  addr_draw;
    logic [7:0]  we_draw;
    logic [71:0] colour_draw;

    typedef struct packed {
        logic [8:0]  addr;
        logic [7:0]  we;
        logic [71:0] col;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   wr_count = 0;

    lb_span_writer dut (
        .clk_draw    (clk_draw),
        .rst_draw_n  (rst_draw_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x       (cmd_x),
        .cmd_len     (cmd_len),
        .cmd_colour  (cmd_colour),
        .busy        (busy),
        .addr_draw   (addr_draw),
        .we_draw     (we_draw),
        .colour_draw (colour_draw)
    );

    initial clk_draw = 1'b0;
    always #5 clk_draw = ~clk_draw;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Pixel-by-pixel model: a new group write starts at the first pixel and at every 8-aligned pixel.
    task automatic push_span(input int x, input int len, input logic [8:0] col);
        exp_t       e;
        logic [11:0] p;
        e = '0;
        for (int i = 0; i < len; i++) begin
            p = 12'((x + i) % 4096);
            if (i != 0 && p[2:0] == 3'd0) exp_q.push_back(e);
            if (i == 0 || p[2:0] == 3'd0) begin
                e.addr = p[11:3];
                e.we   = '0;
                e.col  = {8{col}};
            end
            e.we[3'(7 - int'(p[2:0]))] = 1'b1;
        end
        if (len != 0) exp_q.push_back(e);
    endtask

    // Compare every observed write against the scoreboard head.
    always @(negedge clk_draw) begin
        if (rst_draw_n && we_draw != 8'h00) begin
            exp_t e;
            wr_count++;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_write observed addr=%0h we=%0h expected none", addr_draw, we_draw);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 72'(addr_draw), 72'(e.addr));
                check("wr_we", 72'(we_draw), 72'(e.we));
                check("wr_colour", colour_draw, e.col);
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < 6000) begin
            @(posedge clk_draw); #1;
            n++;
        end
        check("ready_timeout", 72'(cmd_ready), 72'(1'b1));
    endtask

    // Present one command for one accepted cycle; returns at accept edge + 1.
    task automatic send(input int x, input int len, input logic [8:0] col);
        wait_ready();
        cmd_valid  = 1'b1;
        cmd_x      = 12'(x);
        cmd_len    = 13'(len);
        cmd_colour = col;
        push_span(x, len, col);
        @(posedge clk_draw); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 6000) begin
            @(posedge clk_draw); #1;
            n++;
        end
        check("drain_empty", 72'(exp_q.size()), 72'(0));
    endtask

    initial begin
        int          cnt;
        int          base;
        logic        rdy;
        logic [8:0]  col;

        rst_draw_n = 1'b0;
        cmd_valid  = 1'b0;
        cmd_x      = '0;
        cmd_len    = '0;
        cmd_colour = '0;
        #23;
        rst_draw_n = 1'b1;
        @(posedge clk_draw); #1;
        check("rst_ready", 72'(cmd_ready), 72'(1'b1));
        check("rst_busy", 72'(busy), 72'(1'b0));
        check("rst_addr", 72'(addr_draw), 72'(0));
        check("rst_we", 72'(we_draw), 72'(0));
        check("rst_colour", colour_draw, 72'(0));

        // Single partial group, cmd_ready low for exactly one cycle.
        send(5, 3, 9'h1A5);
        check("partial_ready_low", 72'(cmd_ready), 72'(1'b0));
        check("partial_busy", 72'(busy), 72'(1'b1));
        @(posedge clk_draw); #1;
        check("partial_ready_back", 72'(cmd_ready), 72'(1'b1));
        check("partial_we_idle", 72'(we_draw), 72'(0));
        drain();

        // Multi-group span: busy for 3 cycles.
        send(6, 12, 9'h0C3);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy) cnt++;
            @(posedge clk_draw); #1;
        end
        check("multi_busy_cycles", 72'(cnt), 72'(3));
        check("multi_we_idle", 72'(we_draw), 72'(0));
        drain();

        // Wrap across pixel 4095.
        send(4092, 8, 9'h155);
        drain();

        // Zero length: accepted, no write, ready stays high.
        send(100, 0, 9'h1FF);
        check("zero_ready", 72'(cmd_ready), 72'(1'b1));
        check("zero_busy", 72'(busy), 72'(1'b0));
        @(posedge clk_draw); #1;
        check("zero_ready2", 72'(cmd_ready), 72'(1'b1));

        // Back-to-back with the next command held valid: one-cycle bubble.
        send(16, 8, 9'h0AA);
        cmd_valid  = 1'b1;
        cmd_x      = 12'd0;
        cmd_len    = 13'd8;
        cmd_colour = 9'h133;
        push_span(0, 8, 9'h133);
        cnt = 0;
        rdy = 1'b0;
        while (!rdy && cnt < 20) begin
            rdy = cmd_ready;
            @(posedge clk_draw); #1;
            cnt++;
        end
        cmd_valid = 1'b0;
        check("b2b_accept_edge", 72'(cnt), 72'(2));
        drain();

        // Full-line span from an unaligned start: 513 groups.
        send(3, 4096, 9'h07E);
        drain();

        // Assorted random spans.
        for (int i = 0; i < 24; i++) begin
            col = 9'($urandom_range(0, 511));
            send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 40)), col);
        end
        send(4000, 300, 9'h111);
        drain();

        // Reset in the middle of a span.
        base = wr_count;
        send(0, 64, 9'h0F0);
        cnt = 0;
        while (wr_count < base + 3 && cnt < 50) begin
            @(negedge clk_draw);
            cnt++;
        end
        check("mid_third_write", 72'(wr_count - base), 72'(3));
        @(posedge clk_draw); #2;
        rst_draw_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_we", 72'(we_draw), 72'(0));
        check("mid_rst_busy", 72'(busy), 72'(1'b0));
        check("mid_rst_ready", 72'(cmd_ready), 72'(1'b1));
        repeat (2) @(posedge clk_draw);
        #3;
        rst_draw_n = 1'b1;
        @(posedge clk_draw); #1;
        check("post_rst_ready", 72'(cmd_ready), 72'(1'b1));
        base = wr_count;
        repeat (12) @(posedge clk_draw);
        #1;
        check("post_rst_no_writes", 72'(wr_count - base), 72'(0));
        check("post_rst_busy", 72'(busy), 72'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
